// File: rtl/d_reg_pipeline_pkg.sv
// d_reg_pkg: shared definitions for the d_reg_pipeline retiming/buffer chain.
//   DEF_WIDTH / DEF_DEPTH : default data width and stage count
//   stage_state_t         : per-stage occupancy state (also the stage register)
//   occ_width(depth)      : bits needed to count 0..depth valid stages
package d_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_reg_pipeline_stage.sv
// d_reg_stage: one WIDTH-bit register stage of d_reg_pipeline.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   flush     : synchronous clear of the stage valid (data is kept)
//   up_valid  : upstream stage (or masked input) holds a beat
//   up_data   : upstream data
//   dn_acc    : downstream stage will take this stage's beat (or is empty)
//   acc       : this stage can load a new beat this cycle
//   valid_q   : stage holds a beat
//   data_q    : stage data
module d_reg_stage
  import d_reg_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_acc,
  output logic             acc,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  stage_state_t state_q;

  assign valid_q = (state_q == ST_FULL);

  // An empty stage always accepts; a full one only if its beat moves on.
  assign acc = !valid_q || dn_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= RESET_DATA;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else if (acc) begin
      state_q <= up_valid ? ST_FULL : ST_EMPTY;
      // Data only loads with a real beat so idle/X input never lands here.
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/d_reg_pipeline.sv
// d_reg_pipeline: DEPTH-stage valid/ready register chain with bubble
// collapsing and synchronous flush.
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   flush                 : drop every held beat at the next edge
//   in_valid/in_data      : upstream beat;  in_ready : beat accepted this cycle
//   out_valid/out_data    : last-stage beat; out_ready : downstream takes it
//   occupancy (optional)  : registered count of valid stages, present only
//                           when D_REG_PIPELINE_OCCUPANCY_EN is defined
// The ready path is combinational through all DEPTH stages by design.
module d_reg_pipeline
  import d_reg_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               DEPTH      = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef D_REG_PIPELINE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

`ifdef D_REG_PIPELINE_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);
  logic [DEPTH-1:0] valid_vec;
`endif

  // Each stage keeps its handshake nets local so the accept chain is a set
  // of distinct signals rather than one vector depending on itself.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             acc;
    logic             vq;
    logic [WIDTH-1:0] dq;
    logic             dn_acc;
    logic             uv;
    logic [WIDTH-1:0] ud;

    if (i == DEPTH - 1) begin : g_last
      assign dn_acc = out_ready;
    end else begin : g_mid
      assign dn_acc = g_stage[i+1].acc;
    end

    if (i == 0) begin : g_first
      assign uv = in_valid && !flush;
      assign ud = in_data;
    end else begin : g_chain
      assign uv = g_stage[i-1].vq;
      assign ud = g_stage[i-1].dq;
    end

    d_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_DATA(RESET_DATA)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .up_valid(uv),
      .up_data (ud),
      .dn_acc  (dn_acc),
      .acc     (acc),
      .valid_q (vq),
      .data_q  (dq)
    );

`ifdef D_REG_PIPELINE_OCCUPANCY_EN
    assign valid_vec[i] = vq;
`endif
  end

  assign in_ready  = g_stage[0].acc && !flush;
  assign out_valid = g_stage[DEPTH-1].vq;
  assign out_data  = g_stage[DEPTH-1].dq;

`ifdef D_REG_PIPELINE_OCCUPANCY_EN
  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // in_xfer is already blocked during flush, so clearing covers both terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OW'(in_xfer) - OW'(out_xfer);
    end
  end

  a_occ_matches_valids : assert property (
    @(posedge clk) disable iff (rst) occupancy == OW'($countones(valid_vec))
  );
`else
  // Occupancy tracking not built.
`endif

endmodule

// File: tb/tb_d_reg_pipeline.sv
module tb_d_reg_pipeline;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
`ifdef D_REG_PIPELINE_OCCUPANCY_EN
  logic [$clog2(D+1)-1:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  d_reg_pipeline #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_DATA(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef D_REG_PIPELINE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of held beats (oldest first) with the
  // stage index each one currently sits in, plus the last data word that
  // reached the output stage (output data holds between beats).
  int           mpos[$];
  logic [W-1:0] mdat[$];
  logic [W-1:0] mlast = 8'h00;

  // New positions after one edge. A beat advances one stage unless that
  // would collide with the (already moved) beat ahead of it; the head in
  // the last stage leaves only when the consumer is ready.
  function automatic bit plan(input bit ordy, output int np[D]);
    bit leaves = 1'b0;
    for (int k = 0; k < D; k++) np[k] = 0;
    for (int k = 0; k < mpos.size(); k++) begin
      if (k == 0) begin
        if (mpos[0] == D - 1 && ordy) begin
          np[0]  = D;
          leaves = 1'b1;
        end else begin
          np[0] = (mpos[0] + 1 < D - 1) ? mpos[0] + 1 : D - 1;
        end
      end else begin
        np[k] = (mpos[k] + 1 < np[k-1] - 1) ? mpos[k] + 1 : np[k-1] - 1;
      end
    end
    return leaves;
  endfunction

  function automatic bit model_in_ready(input bit fl, input bit ordy);
    int np[D];
    bit lv;
    if (fl) return 1'b0;
    if (mpos.size() == 0) return 1'b1;
    lv = plan(ordy, np);
    return np[mpos.size() - 1] >= 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mpos.delete();
      mdat.delete();
      mlast = 8'h00;
    end else if (flush) begin
      mpos.delete();
      mdat.delete();
    end else begin
      int np[D];
      bit lv;
      bit take;
      take = in_valid && model_in_ready(1'b0, out_ready);
      lv = plan(out_ready, np);
      for (int k = 0; k < mpos.size(); k++) begin
        if (np[k] == D - 1 && mpos[k] != D - 1) mlast = mdat[k];
        mpos[k] = np[k];
      end
      if (lv) begin
        void'(mpos.pop_front());
        void'(mdat.pop_front());
      end
      if (take) begin
        mpos.push_back(0);
        mdat.push_back(in_data);
        if (D == 1) mlast = in_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    bit           e_ov;
    logic [W-1:0] e_od;
    if (rst) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
    end else begin
      e_ov = (mpos.size() > 0) && (mpos[0] == D - 1);
      e_od = mlast;
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      chk("out_data", {24'd0, out_data}, {24'd0, e_od});
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_in_ready(flush, out_ready)});
    end
`ifdef D_REG_PIPELINE_OCCUPANCY_EN
    chk("occupancy", 32'(occupancy), rst ? 32'd0 : 32'(mpos.size()));
`endif
  endtask

  // Inputs are changed 1 ns after a rising edge; outputs are compared on
  // the falling edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           k;
    int           n;
    int           guard;
    int           lat;
    int           sent;
    int           got;
    int           first;
    int           lastc;
    bit           a;
    bit           o;
    logic [W-1:0] od;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1. Reset and single-beat latency
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {24'd0, out_data}, 32'd0);
    tick();
    #7 rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("t1_latency_edges", lat, 32'd3);
    chk("t1_out_data", {24'd0, out_data}, 32'hA5);
    repeat (5) tick();

    // 2. Backpressure fill
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = W'(k + 1);
      #1 a = in_ready;
      tick();
      if (a) k++;
    end
    chk("t2_accepted", k, 32'd4);
    #1;
    chk("t2_full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 6 && guard < 30) begin
      in_valid = (k < 6); in_data = W'(k + 1);
      #1;
      a = in_valid && in_ready;
      o = out_valid; od = out_data;
      tick();
      if (a) k++;
      if (o) begin
        chk("t2_order", {24'd0, od}, 32'(n + 1));
        n++;
      end
      guard++;
    end
    chk("t2_delivered", n, 32'd6);
    in_valid = 1'b0;
    repeat (6) tick();

    // 3. Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h20; tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #1;
    chk("t3_head_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_head_data", {24'd0, out_data}, 32'h10);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t3_second_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_second_data", {24'd0, out_data}, 32'h20);
    tick();
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // 4. Streaming 100 beats
    sent = 0; got = 0; first = -1; lastc = 0;
    for (int c = 0; c < 200 && got < 100; c++) begin
      in_valid = (sent < 100); in_data = W'(sent);
      #1;
      a = in_valid && in_ready;
      o = out_valid; od = out_data;
      tick();
      if (a) sent++;
      if (o) begin
        chk("t4_stream_data", {24'd0, od}, 32'(got & 8'hFF));
        if (first < 0) first = c;
        lastc = c;
        got++;
      end
    end
    in_valid = 1'b0;
    chk("t4_received", got, 32'd100);
    chk("t4_first_cycle", first, 32'd4);
    chk("t4_no_gaps", lastc - first, 32'd99);
    repeat (3) tick();

    // 5. Flush with a 3-beat pipe
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    in_data = 8'hCC; tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1;
    chk("t5_flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_head_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_head_data", {24'd0, out_data}, 32'hAA);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_after_flush", {31'd0, out_valid}, 32'd0);
    repeat (3) tick();
    chk("t5_stay_empty", {31'd0, out_valid}, 32'd0);
    chk("t5_data_held", {24'd0, out_data}, 32'hAA);

    // 6. Asynchronous reset with beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h31; tick();
    in_data = 8'h32; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
`ifdef D_REG_PIPELINE_OCCUPANCY_EN
    chk("t6_pre_occ", 32'(occupancy), 32'd3);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_data", {24'd0, out_data}, 32'd0);
`ifdef D_REG_PIPELINE_OCCUPANCY_EN
    chk("t6_async_occ", 32'(occupancy), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_valid", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with bursty backpressure and occasional flush
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 2 == 0) ? 85 : 30;
      for (int c = 0; c < 60; c++) begin
        in_valid  = ($urandom_range(0, 99) < 70);
        in_data   = W'($urandom);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        flush     = ($urandom_range(0, 39) == 0);
        tick();
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
